// File: rtl/ntt_ram_stream_io_if.sv
// Valid/ready stream bundle for the NTT RAM load/unload front end.
// slave = the front end, master = whoever drives input beats and consumes output beats.
interface ntt_ram_stream_io_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] s_data;
  logic            s_valid;
  logic            s_ready;
  logic [2*DW-1:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ntt_ram_stream_io.sv
// Streaming load/unload front end for the 256x16 dual-port NTT coefficient RAM.
// Define NTT_IO_BITREV_EN to bit-reverse the RAM addresses during LOAD (UNLOAD stays natural).
//
// state    | meaning
// S_IDLE   | NTT core owns the RAM ports, start requests sampled
// S_LOAD   | one input beat written through both ports per accept
// S_UNLOAD | pairwise reads into a 2-entry skid FIFO, streamed out
module ntt_ram_stream_io #(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_load,
  input  logic               start_unload,
  ntt_ram_stream_io_if.slave io,
  output logic               busy,
  output logic               load_done,
  output logic               unload_done,
  output logic [AW-1:0]      ram_addr_a,
  output logic [AW-1:0]      ram_addr_b,
  output logic [DW-1:0]      ram_din_a,
  output logic [DW-1:0]      ram_din_b,
  output logic               ram_we_a,
  output logic               ram_we_b,
  input  logic [DW-1:0]      ram_dout_a,
  input  logic [DW-1:0]      ram_dout_b
);
  localparam int CW = AW - 1;
  localparam logic [CW-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   iss_q, iss_d;
  logic            iss_done_q, iss_done_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [2*DW-1:0] head_q, head_d;
  logic [2*DW-1:0] tail_q, tail_d;
  logic            load_done_q, load_done_d;
  logic            unload_done_q, unload_done_d;

  logic            accept, pop, push, issue;
  logic [2:0]      occ;
  logic [2*DW-1:0] rd_beat;
  logic [AW-1:0]   ld_addr_a, ld_addr_b;

`ifdef NTT_IO_BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  assign ld_addr_a = bitrev({beat_q, 1'b0});
  assign ld_addr_b = bitrev({beat_q, 1'b1});
`else
  assign ld_addr_a = {beat_q, 1'b0};
  assign ld_addr_b = {beat_q, 1'b1};
`endif

  assign rd_beat    = {ram_dout_b, ram_dout_a};
  assign busy       = (state_q != S_IDLE);
  assign load_done  = load_done_q;
  assign unload_done = unload_done_q;

  assign io.s_ready = (state_q == S_LOAD);
  assign io.m_valid = (cnt_q != 2'd0);
  assign io.m_data  = head_q;
  assign io.m_last  = (cnt_q != 2'd0) && (beat_q == LAST_BEAT);

  assign accept = (state_q == S_LOAD) && io.s_valid;
  assign pop    = (cnt_q != 2'd0) && io.m_ready;
  assign push   = inflight_q;
  assign occ    = {1'b0, cnt_q} + {2'b00, inflight_q};
  // A slot freed by this cycle's pop counts, so a drained stream runs at one beat per cycle.
  assign issue  = (state_q == S_UNLOAD) && !iss_done_q && (occ < (pop ? 3'd3 : 3'd2));

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    iss_d         = iss_q;
    iss_done_d    = iss_done_q;
    inflight_d    = issue;
    cnt_d         = cnt_q;
    head_d        = head_q;
    tail_d        = tail_q;
    load_done_d   = 1'b0;
    unload_done_d = 1'b0;
    ram_addr_a    = '0;
    ram_addr_b    = '0;
    ram_din_a     = '0;
    ram_din_b     = '0;
    ram_we_a      = 1'b0;
    ram_we_b      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_load)        state_d = S_LOAD;
        else if (start_unload) state_d = S_UNLOAD;
      end
      S_LOAD: begin
        ram_addr_a = ld_addr_a;
        ram_addr_b = ld_addr_b;
        ram_din_a  = io.s_data[DW-1:0];
        ram_din_b  = io.s_data[2*DW-1:DW];
        ram_we_a   = accept;
        ram_we_b   = accept;
        if (accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      S_UNLOAD: begin
        ram_addr_a = {iss_q, 1'b0};
        ram_addr_b = {iss_q, 1'b1};
        if (issue) begin
          iss_d = iss_q + 1'b1;
          if (iss_q == LAST_BEAT) iss_done_d = 1'b1;
        end
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d       = S_IDLE;
            unload_done_d = 1'b1;
            iss_done_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = rd_beat;
        else               tail_d = rd_beat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = rd_beat;
        end else begin
          head_d = tail_q;
          tail_d = rd_beat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      iss_q         <= '0;
      iss_done_q    <= 1'b0;
      inflight_q    <= 1'b0;
      cnt_q         <= 2'd0;
      head_q        <= '0;
      tail_q        <= '0;
      load_done_q   <= 1'b0;
      unload_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      iss_q         <= iss_d;
      iss_done_q    <= iss_done_d;
      inflight_q    <= inflight_d;
      cnt_q         <= cnt_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      load_done_q   <= load_done_d;
      unload_done_q <= unload_done_d;
    end
  end
endmodule

// File: tb/tb_ntt_ram_stream_io.sv
// Self-checking bench for ntt_ram_stream_io: request table, write/read scoreboards, reset mid-unload.
// Honours NTT_IO_BITREV_EN for the expected LOAD addresses.
module tb_ntt_ram_stream_io;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NB = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load = 1'b0;
  logic          start_unload = 1'b0;
  logic          busy, load_done, unload_done;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a, ram_din_b;
  logic [DW-1:0] ram_dout_a, ram_dout_b;
  logic          ram_we_a, ram_we_b;

  ntt_ram_stream_io_if #(.DW(DW)) sif();

  ntt_ram_stream_io #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .start_load(start_load), .start_unload(start_unload),
    .io(sif.slave),
    .busy(busy), .load_done(load_done), .unload_done(unload_done),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_din_a(ram_din_a), .ram_din_b(ram_din_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_dout_a(ram_dout_a), .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with a registered read, as seen by the front end.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string got, input string want);
    checks++;
    errors++;
    $display("FAIL %s: got %s expected %s", name, got, want);
  endtask

  function automatic logic [AW-1:0] tb_addr(input int i);
    logic [AW-1:0] a, r;
    a = AW'(i);
    r = a;
`ifdef NTT_IO_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
`endif
    return r;
  endfunction

  logic [DW-1:0]   exp_mem [256];
  logic [63:0]     ld_q[$];
  logic [2*DW-1:0] ul_q[$];
  int              cyc = 0;
  int              ld_pulses = 0;
  int              ud_pulses = 0;
  int              acc_n = 0, acc_first = 0, acc_last = 0;
  logic            stall_q = 1'b0;
  logic [2*DW-1:0] hold_q = '0;
  logic [63:0]     e_wr;
  logic [2*DW-1:0] e_rd;

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      stall_q = 1'b0;
    end else begin
      if (ram_we_a || ram_we_b) begin
        if (ld_q.size() == 0) begin
          fail("ram_write", "write with no beat pending", "no write");
        end else begin
          e_wr = ld_q.pop_front();
          chk("ram_write", {14'b0, ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b}, e_wr);
        end
      end
      if (stall_q) chk("stall_hold", {31'b0, sif.m_valid, sif.m_data}, {31'b0, 1'b1, hold_q});
      if (sif.m_valid && sif.m_ready) begin
        if (ul_q.size() == 0) begin
          fail("m_beat", "beat with none pending", "no beat");
        end else begin
          chk("m_last", sif.m_last, ul_q.size() == 1);
          e_rd = ul_q.pop_front();
          chk("m_data", sif.m_data, e_rd);
        end
        if (acc_n == 0) acc_first = cyc;
        acc_last = cyc;
        acc_n++;
      end
      stall_q = sif.m_valid && !sif.m_ready;
      hold_q  = sif.m_data;
      if (load_done)   ld_pulses++;
      if (unload_done) ud_pulses++;
    end
  end

  task automatic load_body(input bit rnd, input bit gaps, input bit poke);
    int lp0, bad;
    logic [2*DW-1:0] d;
    logic [AW-1:0] aa, ab;
    lp0 = ld_pulses;
    for (int k = 0; k < NB; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        sif.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      d  = rnd ? $urandom() : {16'(2*k+1), 16'(2*k)};
      aa = tb_addr(2*k);
      ab = tb_addr(2*k+1);
      ld_q.push_back({14'b0, 2'b11, aa, ab, d[DW-1:0], d[2*DW-1:DW]});
      exp_mem[aa] = d[DW-1:0];
      exp_mem[ab] = d[2*DW-1:DW];
      sif.s_data   = d;
      sif.s_valid  = 1'b1;
      start_unload = poke && (k == 40);
      @(posedge clk); #1;
      start_unload = 1'b0;
    end
    sif.s_valid = 1'b0;
    chk("load_end", {busy, sif.s_ready, load_done}, 3'b001);
    chk("ld_q_drained", ld_q.size(), 0);
    @(posedge clk); #1;
    chk("load_after", {load_done, busy, sif.m_valid}, 3'b000);
    chk("load_done_once", ld_pulses - lp0, 1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk("ram_image_bad_words", bad, 0);
  endtask

  task automatic unload_body(input bit rnd);
    int up0;
    bit done;
    up0   = ud_pulses;
    acc_n = 0;
    for (int k = 0; k < NB; k++) ul_q.push_back({exp_mem[2*k+1], exp_mem[2*k]});
    sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    chk("m_valid_e0", sif.m_valid, 0);
    @(posedge clk); #1;
    chk("m_valid_e1", sif.m_valid, 0);
    @(posedge clk); #1;
    chk("m_valid_e2", sif.m_valid, 1);
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      if (unload_done) begin
        done = 1'b1;
      end else begin
        if (rnd) sif.m_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    if (!done) fail("unload_timeout", "no unload_done in 2000 cycles", "unload_done");
    chk("unload_end", {busy, sif.m_valid, sif.m_last, unload_done}, 4'b0001);
    chk("ul_q_drained", ul_q.size(), 0);
    if (!rnd) chk("back_to_back_span", acc_last - acc_first, NB - 1);
    @(posedge clk); #1;
    chk("unload_done_once", ud_pulses - up0, 1);
    chk("unload_after", {unload_done, busy}, 2'b00);
    sif.m_ready = 1'b0;
  endtask

  typedef struct {
    bit sl;
    bit su;
    bit exp_busy;
    bit exp_s_ready;
    int body;
  } req_t;

  req_t tbl[5];

  initial begin
    tbl[0] = '{sl: 1'b0, su: 1'b0, exp_busy: 1'b0, exp_s_ready: 1'b0, body: 0};
    tbl[1] = '{sl: 1'b1, su: 1'b0, exp_busy: 1'b1, exp_s_ready: 1'b1, body: 1};
    tbl[2] = '{sl: 1'b0, su: 1'b1, exp_busy: 1'b1, exp_s_ready: 1'b0, body: 2};
    tbl[3] = '{sl: 1'b1, su: 1'b1, exp_busy: 1'b1, exp_s_ready: 1'b1, body: 3};
    tbl[4] = '{sl: 1'b0, su: 1'b1, exp_busy: 1'b1, exp_s_ready: 1'b0, body: 4};

    sif.s_data  = '0;
    sif.s_valid = 1'b0;
    sif.m_ready = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;

    #2 rst = 1'b0;
    #1;
    chk("reset_ctrl", {busy, load_done, unload_done, ram_we_a, ram_we_b, sif.s_ready,
                       sif.m_valid, sif.m_last, ram_addr_a, ram_addr_b}, 0);
    chk("reset_data", {ram_din_a, ram_din_b, sif.m_data}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      start_load   = tbl[i].sl;
      start_unload = tbl[i].su;
      @(posedge clk); #1;
      start_load   = 1'b0;
      start_unload = 1'b0;
      chk($sformatf("req%0d_busy_sready", i), {busy, sif.s_ready}, {tbl[i].exp_busy, tbl[i].exp_s_ready});
      case (tbl[i].body)
        1: load_body(1'b0, 1'b0, 1'b0);
        2: unload_body(1'b0);
        3: load_body(1'b1, 1'b1, 1'b1);
        4: unload_body(1'b1);
        default: begin
          @(posedge clk); #1;
          chk("idle_stays", {busy, sif.m_valid}, 2'b00);
        end
      endcase
      @(posedge clk); #1;
      chk($sformatf("req%0d_idle", i), {busy, sif.m_valid}, 2'b00);
    end

    // Reset mid-unload with a full skid FIFO.
    start_unload = 1'b1;
    @(posedge clk); #1;
    start_unload = 1'b0;
    sif.m_ready  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_m_valid", {busy, sif.m_valid}, 2'b11);
    rst = 1'b0;
    #1;
    chk("midreset_ctrl", {busy, load_done, unload_done, ram_we_a, ram_we_b, sif.s_ready,
                          sif.m_valid, sif.m_last, ram_addr_a, ram_addr_b}, 0);
    chk("midreset_data", {ram_din_a, ram_din_b, sif.m_data}, 0);
    ul_q.delete();
    ld_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {busy, sif.m_valid, unload_done}, 3'b000);

    start_load = 1'b1;
    @(posedge clk); #1;
    start_load = 1'b0;
    chk("post_reset_load_entry", {busy, sif.s_ready}, 2'b11);
    load_body(1'b0, 1'b0, 1'b0);
    start_unload = 1'b1;
    @(posedge clk); #1;
    start_unload = 1'b0;
    chk("post_reset_unload_entry", {busy, sif.s_ready}, 2'b10);
    unload_body(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
